// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial shift link: receiver state encoding,
// default word/FIFO geometry and the agreed bit order with the serializer.
package serial_link_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } link_state_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DEPTH = 2;

    // The serializer transmits the word MSB first; the receiver shifts left to match.
    localparam bit MSB_FIRST = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate occupancy counter.
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    // Status decode; a push into a full FIFO only lands when the head leaves in the same cycle.
    always_comb begin
        empty     = (wr_ptr_r == rd_ptr_r);
        full      = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
        pop_ok_s  = pop && !empty;
        push_ok_s = push && (!full || pop_ok_s);
        if (empty) begin
            pop_data = {WIDTH{1'b0}};
        end else begin
            pop_data = mem_r[rd_ptr_r[AW-1:0]];
        end
    end

    // Read and write pointer registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage array, cleared on reset so a stale word can never reappear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel receiver: assembles MSB-first words on qualified shift
// cycles, queues them in a small FIFO and reports framing errors and overruns.
module sipo_deserializer
    import serial_link_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             shift,
    input  logic             frame_start,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun,
    output logic             frame_error,
    input  logic             clear_flags,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    link_state_t      state_r;
    link_state_t      state_s;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_s;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shreg_s;
    logic [WIDTH-1:0] shifted_s;
    logic [WIDTH-1:0] start_word_s;
    logic             push_s;
    logic             pop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             frame_err_evt_s;
    logic             overrun_evt_s;
    logic             overrun_r;
    logic             frame_error_r;
    logic             busy_r;

    // The truncating cast keeps the low WIDTH bits, i.e. a left shift taking serial_in as the new LSB.
    always_comb begin
        shifted_s    = WIDTH'({shreg_r, serial_in});
        start_word_s = {{(WIDTH-1){1'b0}}, serial_in};
    end

    // Receiver next-state logic; the completed word is pushed on the same edge its last bit is sampled.
    always_comb begin
        state_s         = state_r;
        count_s         = count_r;
        shreg_s         = shreg_r;
        push_s          = 1'b0;
        frame_err_evt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (shift && frame_start) begin
                    shreg_s = start_word_s;
                    count_s = CNT_ONE;
                    state_s = RECV;
                end else begin
                    state_s = IDLE;
                end
            end
            RECV: begin
                if (shift && frame_start) begin
                    frame_err_evt_s = 1'b1;
                    shreg_s         = start_word_s;
                    count_s         = CNT_ONE;
                end else if (shift) begin
                    shreg_s = shifted_s;
                    if (count_r == CNT_LAST) begin
                        push_s  = 1'b1;
                        count_s = CNT_ZERO;
                        state_s = IDLE;
                    end else begin
                        count_s = count_r + CNT_ONE;
                    end
                end else begin
                    state_s = RECV;
                end
            end
            default: begin
                state_s = IDLE;
                count_s = CNT_ZERO;
                shreg_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // Handshake decode; a word is lost only when it completes into a full FIFO that is not draining.
    always_comb begin
        data_valid    = !fifo_empty_s;
        pop_s         = data_valid && data_ready;
        overrun_evt_s = push_s && fifo_full_s && !pop_s;
    end

    // Receiver state, bit counter and shift register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            count_r <= CNT_ZERO;
            shreg_r <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            shreg_r <= shreg_s;
            busy_r  <= (state_s == RECV);
        end
    end

    // Sticky error flags; a new event outranks a coincident clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun_r     <= 1'b0;
            frame_error_r <= 1'b0;
        end else begin
            if (overrun_evt_s) begin
                overrun_r <= 1'b1;
            end else if (clear_flags) begin
                overrun_r <= 1'b0;
            end
            if (frame_err_evt_s) begin
                frame_error_r <= 1'b1;
            end else if (clear_flags) begin
                frame_error_r <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_s),
        .push_data (shifted_s),
        .pop       (pop_s),
        .pop_data  (data_out),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign overrun     = overrun_r;
    assign frame_error = frame_error_r;
    assign busy        = busy_r;

endmodule
